// File: rtl/cmp_pkg.sv
// cmp_pkg: shared result type and merge rule for the pipelined comparator
package cmp_pkg;
  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_res_t;
  localparam cmp_res_t CMP_EQ = 3'b010;
  function automatic cmp_res_t merge_res(input cmp_res_t slice_res, input cmp_res_t prior_res);
    return (slice_res == CMP_EQ) ? prior_res : slice_res;
  endfunction
endpackage

// File: rtl/cmp_slice.sv
// cmp_slice: compares one CHUNK-bit slice and merges it with the running result
// ports: a_i/b_i slice operands, invert_msb_i flips slice MSB (signed top slice),
//        prior_i incoming running result, res_o merged one-hot result
module cmp_slice
  import cmp_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             invert_msb_i,
  input  cmp_res_t         prior_i,
  output cmp_res_t         res_o
);
  logic [CHUNK-1:0] flip;
  logic [CHUNK-1:0] a_x;
  logic [CHUNK-1:0] b_x;
  cmp_res_t         slice_res;
  // flipping the sign bit maps two's-complement order onto unsigned order
  assign flip      = CHUNK'(invert_msb_i) << (CHUNK - 1);
  assign a_x       = a_i ^ flip;
  assign b_x       = b_i ^ flip;
  assign slice_res = '{lt: a_x < b_x, eq: a_x == b_x, gt: a_x > b_x};
  assign res_o     = merge_res(slice_res, prior_i);
endmodule

// File: rtl/cmp_pipe.sv
// cmp_pipe: pipelined magnitude comparator, one CHUNK slice per stage, LSB slice first
// ports: in_valid/in_ready/in_a/in_b/in_signed operand handshake,
//        out_valid/out_ready result handshake, out_lt/out_eq/out_gt one-hot flags,
//        out_min/out_max ordered operands (min=A, max=B when equal)
module cmp_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_lt,
  output logic             out_eq,
  output logic             out_gt,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int LAST   = NCHUNK - 1;
  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("cmp_pipe: WIDTH must be a multiple of CHUNK");
  end
  logic             advance;
  logic             v_q     [NCHUNK];
  logic             v_s     [NCHUNK];
  logic             sgn_q   [NCHUNK];
  logic             sgn_s   [NCHUNK];
  cmp_res_t         res_q   [NCHUNK];
  cmp_res_t         prior_s [NCHUNK];
  cmp_res_t         res_d   [NCHUNK];
  logic [WIDTH-1:0] a_q     [NCHUNK];
  logic [WIDTH-1:0] b_q     [NCHUNK];
  logic [WIDTH-1:0] a_s     [NCHUNK];
  logic [WIDTH-1:0] b_s     [NCHUNK];
  assign out_valid = v_q[LAST];
  // the whole pipe moves in lockstep, so bubbles are carried rather than squeezed out
  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;
  genvar k;
  for (k = 0; k < NCHUNK; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign v_s[k]     = in_valid;
      assign sgn_s[k]   = in_signed;
      assign prior_s[k] = CMP_EQ;
      assign a_s[k]     = in_a;
      assign b_s[k]     = in_b;
    end else begin : g_body
      assign v_s[k]     = v_q[k-1];
      assign sgn_s[k]   = sgn_q[k-1];
      assign prior_s[k] = res_q[k-1];
      assign a_s[k]     = a_q[k-1];
      assign b_s[k]     = b_q[k-1];
    end
    cmp_slice #(.CHUNK(CHUNK)) u_slice (
      .a_i          (a_s[k][k*CHUNK +: CHUNK]),
      .b_i          (b_s[k][k*CHUNK +: CHUNK]),
      .invert_msb_i (k == LAST ? sgn_s[k] : 1'b0),
      .prior_i      (prior_s[k]),
      .res_o        (res_d[k])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCHUNK; i++) begin
        v_q[i]   <= 1'b0;
        sgn_q[i] <= 1'b0;
        res_q[i] <= '0;
        a_q[i]   <= '0;
        b_q[i]   <= '0;
      end
    end else if (advance) begin
      for (int i = 0; i < NCHUNK; i++) begin
        v_q[i]   <= v_s[i];
        sgn_q[i] <= sgn_s[i];
        res_q[i] <= res_d[i];
        a_q[i]   <= a_s[i];
        b_q[i]   <= b_s[i];
      end
    end
  end
  assign out_lt  = res_q[LAST].lt;
  assign out_eq  = res_q[LAST].eq;
  assign out_gt  = res_q[LAST].gt;
  assign out_min = res_q[LAST].gt ? b_q[LAST] : a_q[LAST];
  assign out_max = res_q[LAST].gt ? a_q[LAST] : b_q[LAST];
endmodule
